// File: rtl/uart_tx_frame_gen.sv
// UART transmitter: pops words from a FWFT buffer and sends start/data/parity/stop frames back to back.
// Optional line-break support is compiled in with `define UART_TX_BREAK_EN (adds input tx_break).
module uart_tx_frame_gen #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_buf_not_empty,
`ifdef UART_TX_BREAK_EN
    input  logic                 tx_break,
`endif
    output logic                 tx_read_buf,
    output logic                 tx_pin_out,
    output logic                 tx_busy
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    generate
        if (DIV < 4) begin : g_bad_div
            $error("uart_tx_frame_gen: CLK_FREQ/BAUD must be >= 4");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_frame_gen: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_frame_gen: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_frame_gen: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
`ifdef UART_TX_BREAK_EN
        ,
        BRK,
        MAB
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   pin_q, pin_d;
    logic                   busy_q, busy_d;
    logic                   pop_q, pop_d;
    logic                   baud_done;
    logic                   load;

    assign baud_done = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = baud_done ? '0 : cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pin_d   = pin_q;
        busy_d  = busy_q;
        pop_d   = 1'b0;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                pin_d  = 1'b1;
                busy_d = 1'b0;
`ifdef UART_TX_BREAK_EN
                if (tx_break) begin
                    state_d = BRK;
                    pin_d   = 1'b0;
                    busy_d  = 1'b1;
                end else
`endif
                if (tx_buf_not_empty) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (baud_done) begin
                    state_d = DATA;
                    pin_d   = shift_q[0];
                end
            end
            DATA: begin
                if (baud_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = PAR;
                            pin_d   = par_q;
                        end else begin
                            state_d = STOP;
                            pin_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        pin_d = shift_q[1];
                    end
                end
            end
            PAR: begin
                if (baud_done) begin
                    state_d = STOP;
                    pin_d   = 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_BREAK_EN
                        if (tx_break) begin
                            state_d = BRK;
                            pin_d   = 1'b0;
                        end else
`endif
                        if (tx_buf_not_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            pin_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            BRK: begin
                cnt_d = '0;
                if (!tx_break) begin
                    state_d = MAB;
                    pin_d   = 1'b1;
                end
            end
            // mark-after-break: one full bit time high before IDLE may start a frame
            MAB: begin
                if (baud_done) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                pin_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Frame start shared by IDLE and the zero-gap STOP exit
        if (load) begin
            state_d = START;
            cnt_d   = '0;
            bit_d   = '0;
            shift_d = tx_data;
            par_d   = (PARITY == 1) ? ~(^tx_data) : (^tx_data);
            pin_d   = 1'b0;
            busy_d  = 1'b1;
            pop_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            pin_q   <= 1'b1;
            busy_q  <= 1'b0;
            pop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            pin_q   <= pin_d;
            busy_q  <= busy_d;
            pop_q   <= pop_d;
        end
    end

    assign tx_read_buf = pop_q;
    assign tx_pin_out  = pin_q;
    assign tx_busy     = busy_q;

endmodule
